// File: rtl/normalizer_pkg.sv
// Shared CPU-wide package: normalizer state encoding, mode constants, widths.
package normalizer_pkg;

  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 4;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // One state per shift stage; the stage amount halves each step.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S8   = 3'd1,
    S4   = 3'd2,
    S2   = 3'd3,
    S1   = 3'd4
  } state_e;

  // Shift amount selected by the 2-bit stage select (0 -> 8, 1 -> 4, 2 -> 2, 3 -> 1).
  function automatic logic [SHAMT_W-1:0] stageShift(input logic [1:0] kSel);
    logic [SHAMT_W-1:0] k;
    case (kSel)
      2'd0:    k = 4'd8;
      2'd1:    k = 4'd4;
      2'd2:    k = 4'd2;
      default: k = 4'd1;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/normalizer_if.sv
// Start/done handshake and result bus between a requester and the normalizer.
interface normalizer_if;
  import normalizer_pkg::*;

  logic                start;
  logic [DATA_W-1:0]   src;
  logic                signed_mode;
  logic                busy;
  logic                done;
  logic [DATA_W-1:0]   out;
  logic [SHAMT_W-1:0]  shamt;
  logic                zr;

  modport master (
    output start, src, signed_mode,
    input  busy, done, out, shamt, zr
  );

  modport slave (
    input  start, src, signed_mode,
    output busy, done, out, shamt, zr
  );

endinterface

// File: rtl/normalizer_stage.sv
// One combinational normalize stage: decides whether a shift of k is safe and
// provides the shifted value. k is chosen by a 2-bit select.
module normalizer_stage
  import normalizer_pkg::*;
(
  input  logic [DATA_W-1:0] value_i,
  input  logic [1:0]        kSel_i,
  input  logic              mode_i,
  output logic              taken_o,
  output logic [DATA_W-1:0] shifted_o
);

  logic [DATA_W-1:0] zeroMask;
  logic [DATA_W-1:0] signMask;
  logic [DATA_W-1:0] signBits;

  // Pick the top-k mask (unsigned), the top-(k+1) mask (signed) and the shifted value.
  always_comb begin
    zeroMask  = '0;
    signMask  = '0;
    shifted_o = value_i;
    case (kSel_i)
      2'd0: begin
        zeroMask  = 16'hFF00;
        signMask  = 16'hFF80;
        shifted_o = value_i << 8;
      end
      2'd1: begin
        zeroMask  = 16'hF000;
        signMask  = 16'hF800;
        shifted_o = value_i << 4;
      end
      2'd2: begin
        zeroMask  = 16'hC000;
        signMask  = 16'hE000;
        shifted_o = value_i << 2;
      end
      default: begin
        zeroMask  = 16'h8000;
        signMask  = 16'hC000;
        shifted_o = value_i << 1;
      end
    endcase
  end

  // Unsigned: the top k bits are all zero. Signed: the top k+1 bits all match.
  always_comb begin
    signBits = value_i & signMask;
    if (mode_i == MODE_SIGNED) begin
      taken_o = (signBits == '0) || (signBits == signMask);
    end else begin
      taken_o = ((value_i & zeroMask) == '0);
    end
  end

endmodule

// File: rtl/normalizer.sv
// Multi-cycle left normalizer: four fixed binary-search stages (8/4/2/1) find the
// shift that brings the leading significant bit into bit 15.
module normalizer
  import normalizer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  normalizer_if.slave bus
);

  state_e              state_q;
  logic [DATA_W-1:0]   work_q;
  logic [DATA_W-1:0]   work_d;
  logic [SHAMT_W-1:0]  count_q;
  logic [SHAMT_W-1:0]  count_d;
  logic                mode_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_W-1:0]   out_q;
  logic [SHAMT_W-1:0]  shamt_q;
  logic                zr_q;

  logic [1:0]          kSel;
  logic                stageTaken;
  logic [DATA_W-1:0]   stageShifted;

  // The current state decides which stage amount the shared stage evaluates.
  always_comb begin
    kSel = 2'd0;
    case (state_q)
      S8:      kSel = 2'd0;
      S4:      kSel = 2'd1;
      S2:      kSel = 2'd2;
      S1:      kSel = 2'd3;
      default: kSel = 2'd0;
    endcase
  end

  normalizer_stage u_stage (
    .value_i   (work_q),
    .kSel_i    (kSel),
    .mode_i    (mode_q),
    .taken_o   (stageTaken),
    .shifted_o (stageShifted)
  );

  // Post-stage work value and shift count; the count cannot exceed 15.
  always_comb begin
    work_d  = work_q;
    count_d = count_q;
    if (stageTaken) begin
      work_d  = stageShifted;
      count_d = count_q + stageShift(kSel);
    end
  end

  // Control FSM with registered busy/done and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      count_q <= '0;
      mode_q  <= MODE_UNSIGNED;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      shamt_q <= '0;
      zr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            work_q  <= bus.src;
            mode_q  <= bus.signed_mode;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S8;
          end
        end
        S8: begin
          work_q  <= work_d;
          count_q <= count_d;
          state_q <= S4;
        end
        S4: begin
          work_q  <= work_d;
          count_q <= count_d;
          state_q <= S2;
        end
        S2: begin
          work_q  <= work_d;
          count_q <= count_d;
          state_q <= S1;
        end
        S1: begin
          work_q  <= work_d;
          count_q <= count_d;
          out_q   <= work_d;
          shamt_q <= count_d;
          zr_q    <= ~|work_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.out   = out_q;
  assign bus.shamt = shamt_q;
  assign bus.zr    = zr_q;

endmodule

// File: tb/tb_normalizer.sv
// Testbench for normalizer: directed corner cases, random operands, back-to-back
// starts and a mid-operation reset, all checked against a leading-bit-count model.
module tb_normalizer;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [15:0] heldOut;
  logic [3:0]  heldShamt;
  logic        heldZr;

  logic [15:0] bSrc  [20];
  logic        bMode [20];

  normalizer_if bus ();

  normalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time guard so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: shift = number of leading zeros (unsigned) or redundant sign bits
  // (signed), capped at 15; result is the operand shifted left by that amount.
  function automatic void refNorm(input logic [15:0] v, input logic m,
                                  output logic [15:0] o, output logic [3:0] s);
    int n;
    n = 0;
    if (m == 1'b0) begin
      while (n < 16 && v[15-n] == 1'b0) n++;
    end else begin
      while (n < 15 && v[14-n] == v[15]) n++;
    end
    if (n > 15) n = 15;
    s = 4'(n);
    o = v << n;
  endfunction

  // Run one normalization from an idle/done cycle and check timing and results.
  task automatic applyStimulus(input logic [15:0] value, input logic mode);
    logic [15:0] expOut;
    logic [3:0]  expShamt;
    int          busyCnt;
    int          latency;
    refNorm(value, mode, expOut, expShamt);
    bus.start       = 1'b1;
    bus.src         = value;
    bus.signed_mode = mode;
    @(posedge clk); #1;
    bus.start       = 1'b0;
    bus.src         = 16'($urandom);
    bus.signed_mode = 1'($urandom);
    busyCnt = bus.busy ? 1 : 0;
    latency = 9;
    for (int i = 1; i <= 8; i++) begin
      checkOutput("outHeld", bus.out, heldOut);
      checkOutput("shamtHeld", bus.shamt, heldShamt);
      @(posedge clk); #1;
      if (bus.done) begin
        latency = i;
        break;
      end
      if (bus.busy) busyCnt++;
    end
    checkOutput("latency", latency, 4);
    checkOutput("busyCycles", busyCnt, 4);
    checkOutput("busyInDone", bus.busy, 1'b0);
    checkOutput("out", bus.out, expOut);
    checkOutput("shamt", bus.shamt, expShamt);
    checkOutput("zr", bus.zr, (expOut == 16'h0000));
    heldOut   = expOut;
    heldShamt = expShamt;
    heldZr    = (expOut == 16'h0000);
  endtask

  typedef struct {
    logic [15:0] value;
    logic        mode;
  } vec_t;

  initial begin
    vec_t directed [10];
    logic [15:0] expOut;
    logic [3:0]  expShamt;

    vectors     = 0;
    miscompares = 0;
    heldOut     = 16'h0000;
    heldShamt   = 4'd0;
    heldZr      = 1'b0;

    bus.start       = 1'b0;
    bus.src         = 16'h0000;
    bus.signed_mode = 1'b0;
    rst_n           = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstBusy", bus.busy, 1'b0);
    checkOutput("rstDone", bus.done, 1'b0);
    checkOutput("rstOut", bus.out, 16'h0000);
    checkOutput("rstShamt", bus.shamt, 4'd0);
    checkOutput("rstZr", bus.zr, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases.
    directed[0] = '{16'h0001, 1'b0};
    directed[1] = '{16'h00F0, 1'b0};
    directed[2] = '{16'h8000, 1'b0};
    directed[3] = '{16'hFFF0, 1'b1};
    directed[4] = '{16'h0003, 1'b1};
    directed[5] = '{16'hFFFF, 1'b1};
    directed[6] = '{16'h0000, 1'b0};
    directed[7] = '{16'h0000, 1'b1};
    directed[8] = '{16'h4000, 1'b1};
    directed[9] = '{16'hFFFF, 1'b0};
    foreach (directed[i]) applyStimulus(directed[i].value, directed[i].mode);

    // Random operands, with a bias toward small magnitudes to reach deep shifts.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if (i % 3 == 1) v = v >> $urandom_range(15, 0);
      if (i % 3 == 2) v = 16'(signed'(v) >>> $urandom_range(15, 0));
      applyStimulus(v, 1'($urandom));
    end

    // start held high: acceptances every 5 edges, done one edge before each new accept.
    for (int e = 0; e < 20; e++) begin
      bSrc[e]         = 16'($urandom >> $urandom_range(16, 0));
      bMode[e]        = 1'($urandom);
      bus.start       = 1'b1;
      bus.src         = bSrc[e];
      bus.signed_mode = bMode[e];
      @(posedge clk); #1;
      checkOutput("b2bDone", bus.done, (e % 5 == 4));
      checkOutput("b2bBusy", bus.busy, (e % 5 != 4));
      if (e % 5 == 4) begin
        refNorm(bSrc[e-4], bMode[e-4], expOut, expShamt);
        checkOutput("b2bOut", bus.out, expOut);
        checkOutput("b2bShamt", bus.shamt, expShamt);
        checkOutput("b2bZr", bus.zr, (expOut == 16'h0000));
        heldOut   = expOut;
        heldShamt = expShamt;
        heldZr    = (expOut == 16'h0000);
      end
    end
    bus.start = 1'b0;

    // Make sure the result registers hold a nonzero value before the reset test.
    applyStimulus(16'h0101, 1'b0);

    // Reset asserted while the request sits in S4.
    bus.start       = 1'b1;
    bus.src         = 16'h1234;
    bus.signed_mode = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", bus.busy, 1'b0);
    checkOutput("midRstDone", bus.done, 1'b0);
    checkOutput("midRstOut", bus.out, 16'h0000);
    checkOutput("midRstShamt", bus.shamt, 4'd0);
    checkOutput("midRstZr", bus.zr, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("midRstNoDone", bus.done, 1'b0);
    end
    rst_n     = 1'b1;
    heldOut   = 16'h0000;
    heldShamt = 4'd0;
    heldZr    = 1'b0;
    @(posedge clk); #1;
    checkOutput("postRstNoDone", bus.done, 1'b0);
    applyStimulus(16'h0400, 1'b0);
    checkOutput("postRstOut", bus.out, 16'h8000);
    checkOutput("postRstShamt", bus.shamt, 4'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/normalizer.md
# normalizer

Multi-cycle left-normalizer for the 16-bit datapath; the inverse of the barrel shifter's SLL/SRA paths. Given an operand, it computes the left-shift amount that moves the leading significant bit into bit 15, and the normalized result. Unsigned mode normalizes leading zeros; signed mode normalizes redundant sign bits. It sits beside the ALU shifter and serves count-leading-bits / normalize operations through a start/done handshake.

## Interface
- No parameters; width fixed at 16, shift amount fixed at 4 bits.
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when not busy
- src  input  16  operand, captured on accepted start
- signed_mode  input  1  0 = leading zeros, 1 = redundant sign bits; captured with src
- busy  output  1  high while a normalization is in flight
- done  output  1  one-cycle pulse when results update
- out  output  16  normalized value, held until next completion
- shamt  output  4  left shift applied (0..15), held
- zr  output  1  out == 0, held

## Operation
- States: IDLE, S8, S4, S2, S1. Encoding lives in the shared package.
- IDLE & start: capture src/signed_mode into the work register and mode register, clear count, go to S8. start while busy is ignored (not queued).
- Stage k (k = 8, 4, 2, 1 in S8, S4, S2, S1): test the work register w.
  - Unsigned: taken if w[15:16-k] == 0.
  - Signed: taken if w[15:15-k] are all equal (k+1 bits).
  - If taken: w <= w << k (zero fill), count += k.
- S8→S4→S2→S1 unconditionally. On the S1 edge, apply stage 1 and load out/shamt/zr from the post-stage value. Pulse done and return to IDLE.
- Zero operand (either mode): every stage taken; out = 0, shamt = 15, zr = 1.
- Signed 0xFFFF: shamt = 15, out = 0x8000, zr = 0.
- Already-normalized operands (unsigned bit15 = 1; signed bit15 != bit14): shamt = 0, out = src.
- count is 4 bits; the maximum sum is 8+4+2+1 = 15, so it never overflows.
- zr = ~|out, computed from the value being loaded, registered with out.

## Timing
- Edge E0 accepts start. Stages 8/4/2/1 are applied at E1/E2/E3/E4. Results and done are visible after E4. Fixed latency is 4 cycles from the accepting edge; there is no early exit.
- busy is high after E0 through the cycle before E4 (S8..S1), and low in the done cycle.
- Back-to-back: start asserted during the done cycle is accepted at that edge. Sustained throughput is one result per 5 cycles.
- out/shamt/zr change only at completion edges; they are stable between completions, including while busy.
- Reset (any time, including mid-operation): state goes to IDLE, busy = 0, done = 0, out = 0x0000, shamt = 0, zr = 0. The work register and count are cleared, and the in-flight request is discarded. The first start after rst_n rises is accepted normally.
- src/signed_mode are don't-care except at the accepting edge.

## Structure
- Shared package (the CPU-wide package): the state enum (IDLE, S8, S4, S2, S1), the mode constants MODE_UNSIGNED = 0 and MODE_SIGNED = 1, and the data/shift widths (16, 4).
- One sub-module, normalizer_stage. It is combinational: inputs are value, k (constant per instance or a 2-bit select), and mode; outputs are taken and the shifted value. Instantiate once with a muxed k selected by state.
- Top: FSM, work/count/mode registers, output registers.

## Test plan
- Unsigned 0x0001, start -> done after 4 cycles; out = 0x8000, shamt = 15, zr = 0; busy high exactly 4 cycles.
- Unsigned 0x00F0 -> out = 0xF000, shamt = 8. Unsigned 0x8000 -> out = 0x8000, shamt = 0.
- Signed 0xFFF0 -> out = 0x8000, shamt = 11. Signed 0x0003 -> out = 0x6000, shamt = 13. Signed 0xFFFF -> out = 0x8000, shamt = 15, zr = 0.
- Zero operand in each mode -> out = 0, shamt = 15, zr = 1.
- start held high continuously with changing src -> accepts only in IDLE/done cycles, one done per 5 cycles. Each result matches the src present at its accepting edge.
- rst_n pulsed low during S4 -> all outputs 0 immediately (asynchronously), no done pulse. A following start of unsigned 0x0400 -> out = 0x8000, shamt = 5.
